mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port 128x16 word memory between two requesters: port 0 = CPU, port 1 = loader/debug.
//  Accepts one access per cycle, with round-robin fairness and an optional bounded lock for back-to-back bursts.
//  Returns read data one cycle after grant.
//  Sits between the CPU/loader and the Memory instance; the memory sees only the arbiter's mem_* outputs.
// PARAMETERS
//  AW        8   requester byte-address width; word address = addr[AW-1:1]
//  DW        16  data width
//  LOCK_MAX  4   max consecutive grants to one port while its lock is held; range 1..15
// PORTS
//  clk        in   1    system clock; all state updates on posedge
//  rst_n      in   1    asynchronous, active-low reset
//  req[1:0]   in   2    per-port request; held high until gnt
//  we[1:0]    in   2    per-port write enable; qualified by req
//  lock[1:0]  in   2    per-port burst lock hint
//  addr0/1    in   AW   per-port byte address; bit 0 ignored
//  wdata0/1   in   DW   per-port write data
//  gnt[1:0]   out  2    one-hot, 1-cycle pulse; access issued this cycle
//  rvalid[1:0] out 2    1-cycle pulse, cycle after a read gnt
//  rdata      out  DW   read data, valid with rvalid
//  mem_we     out  1    to Memory write enable
//  mem_addr   out  AW-1 to Memory word address
//  mem_wdata  out  DW   to Memory write data
//  mem_rdata  in   DW   from Memory; combinational read of mem_addr
// BEHAVIOUR
//  Reset (async on rst_n low):
//   gnt=0, rvalid=0, rdata=0, mem_we=0, mem_addr=0, mem_wdata=0, state=IDLE, last=1 (port 0 first), lock_cnt=0.
//  Grant and memory drive (combinational, same cycle as request):
//   - gnt is combinational from req and registered state.
//   - Granted port's we/addr[AW-1:1]/wdata drive mem_*.
//   - No grant: mem_we=0; mem_addr/mem_wdata hold the last driven values.
//  Read data (registered):
//   - rvalid[p]=1 on the cycle after a read grant to port p.
//   - rdata = mem_rdata sampled at the grant edge.
//   - Write grant -> no rvalid.
//  Arbitration FSM states:
//   - IDLE: no owner; one requester -> grant it; both -> grant ~last; go OWN0/OWN1.
//   - OWNp: if req[p]&lock[p] and lock_cnt<LOCK_MAX -> grant p again, lock_cnt++;
//     else release, arbitrate as IDLE with last=p.
//   - No req -> IDLE.
//   - lock_cnt clears on any owner change.
//  Fairness: with both requesting continuously and no lock, grants strictly alternate.
//   Lock starves the other port for at most LOCK_MAX cycles.
//  Boundaries:
//   - lock without req is ignored.
//   - Req dropped before grant -> no access, no rvalid.
//   - Read and write at the same word on consecutive grants: read sees the new data
//     (memory write on edge, read combinational next cycle).
//   - rst_n asserted mid-access: any pending rvalid is discarded; no partial write (mem_we forced 0 asynchronously).
//  Widths: lock_cnt is 4 bits. addr bit 0 is dropped without error.
// STRUCTURE
//  Package mem_arb_pkg: typedef enum {IDLE, OWN0, OWN1} arb_state_t; localparams PORT_CPU=0, PORT_LDR=1.
//  Sub-module rr_pick2: 2-way round-robin picker (req, last -> one-hot pick), combinational.
//  Top holds the FSM, lock counter, mux and read-return register.
// TESTING
//  1. Reset: rst_n=0 with random inputs -> all outputs 0; after release with req=00 -> gnt=00, mem_we=0.
//  2. Single write/read, port 0:
//     write addr0=8'h04, wdata0=16'h000A -> gnt=01, mem_addr=7'h02, mem_we=1;
//     then read 8'h04 -> next cycle rvalid=01, rdata=16'h000A.
//  3. Contention: req=11, both reads, no lock, 6 cycles -> gnt sequence 01,10,01,10,01,10.
//  4. Lock bound: LOCK_MAX=4, port 1 lock=1, req=11 for 8 cycles -> gnt 10 x5 (initial + 4), then 01, then 10.
//  5. Write-then-read hazard: port 1 writes 16'hBEEF to 8'h10, port 0 reads 8'h10 next cycle -> rvalid=01, rdata=16'hBEEF.
//  6. Mid-access reset: rst_n low during a read-grant cycle -> no rvalid after release; memory contents unchanged.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam bit PORT_CPU = 1'b0;
    localparam bit PORT_LDR = 1'b1;

    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, on contention the port
// that was not served last wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] pick_c
);

    // One-hot pick from request vector and last-served port
    always_comb begin
        pick_c = 2'b00;
        unique case (req)
            2'b01:   pick_c = 2'b01;
            2'b10:   pick_c = 2'b10;
            2'b11:   pick_c = last ? 2'b01 : 2'b10;
            default: pick_c = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port word memory between the CPU (port 0) and the
// loader/debug port (port 1), with round-robin fairness and a bounded lock.
module mem_port_arbiter #(
    parameter int unsigned AW       = 8,
    parameter int unsigned DW       = 16,
    parameter int unsigned LOCK_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    req,
    input  logic [1:0]    we,
    input  logic [1:0]    lock,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic [1:0]    gnt,
    output logic [1:0]    rvalid,
    output logic [DW-1:0] rdata,
    output logic          mem_we,
    output logic [AW-2:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    import mem_arb_pkg::*;

    arb_state_t       state_q, state_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       pick_c;
    logic [1:0]       gnt_int;
    logic             cnt_below;
    logic [AW-2:0]    addr_q;
    logic [DW-1:0]    wdata_q;
    logic [1:0]       rvalid_q;
    logic [DW-1:0]    rdata_q;
    logic             unused_addr_lsb;

    // Byte-address bit 0 carries no word information
    assign unused_addr_lsb = addr0[0] ^ addr1[0];

    rr_pick2 u_pick (
        .req    (req),
        .last   (last_q),
        .pick_c (pick_c)
    );

    assign cnt_below = (cnt_q < CNT_W'(LOCK_MAX));

    // Next-state: lock continuation for the owner, otherwise round-robin
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = '0;
        gnt_int = 2'b00;

        unique case (state_q)
            OWN0: begin
                if (req[PORT_CPU] && lock[PORT_CPU] && cnt_below) begin
                    gnt_int = 2'b01;
                    cnt_d   = cnt_q + CNT_W'(1);
                end else begin
                    gnt_int = pick_c;
                end
            end
            OWN1: begin
                if (req[PORT_LDR] && lock[PORT_LDR] && cnt_below) begin
                    gnt_int = 2'b10;
                    cnt_d   = cnt_q + CNT_W'(1);
                end else begin
                    gnt_int = pick_c;
                end
            end
            default: gnt_int = pick_c;
        endcase

        // Reset blocks any access immediately, including a half-issued write
        if (!rst_n) begin
            gnt_int = 2'b00;
        end

        if (gnt_int[PORT_CPU]) begin
            state_d = OWN0;
            last_d  = PORT_CPU;
        end else if (gnt_int[PORT_LDR]) begin
            state_d = OWN1;
            last_d  = PORT_LDR;
        end else begin
            state_d = IDLE;
        end
    end

    // Memory drive: granted port's request, else hold last address/data
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (gnt_int[PORT_CPU]) begin
            mem_we    = we[PORT_CPU];
            mem_addr  = addr0[AW-1:1];
            mem_wdata = wdata0;
        end else if (gnt_int[PORT_LDR]) begin
            mem_we    = we[PORT_LDR];
            mem_addr  = addr1[AW-1:1];
            mem_wdata = wdata1;
        end
    end

    assign gnt = gnt_int;

    // Arbitration state, last-served port and lock counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= PORT_LDR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Remember the last driven address/data for idle cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (|gnt_int) begin
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
        end
    end

    // Read return: capture memory data at the read-grant edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 2'b00;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= gnt_int & ~we;
            if (|(gnt_int & ~we)) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural 128x16 memory.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, we, lock;
    logic [7:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic [1:0]  gnt, rvalid;
    logic [15:0] rdata;
    logic        mem_we;
    logic [6:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;

    mem_port_arbiter #(.AW(8), .DW(16), .LOCK_MAX(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .lock      (lock),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory instance model: write on edge, combinational read
    logic [15:0] mem [128];
    logic [15:0] shadow [128];
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] cyc;
        logic [1:0]  gnt;
        logic        we;
        logic [6:0]  addr;
        logic [15:0] wdata;
    } gexp_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic [1:0]  rv;
        logic [15:0] rdata;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every grant and every rvalid must match the next queued expectation
    always @(negedge clk) begin
        gexp_t ga;
        rexp_t ra;
        if (gnt !== 2'b00) begin
            ga = '{32'(cyc), gnt, mem_we, mem_addr, mem_wdata};
            if (gq.size() == 0) check("gnt_unexpected", 64'(ga), 64'(0));
            else check("gnt", 64'(ga), 64'(gq.pop_front()));
        end
        if (rvalid !== 2'b00) begin
            ra = '{32'(cyc), rvalid, rdata};
            if (rq.size() == 0) check("rvalid_unexpected", 64'(ra), 64'(0));
            else check("rvalid", 64'(ra), 64'(rq.pop_front()));
        end
    end

    // One cycle of stimulus; eg is the hand-computed grant for this cycle
    task automatic step(input logic [1:0] r, input logic [1:0] w, input logic [1:0] l,
                        input logic [7:0] a0, input logic [15:0] d0,
                        input logic [7:0] a1, input logic [15:0] d1,
                        input logic [1:0] eg);
        logic        p;
        logic [6:0]  wa;
        logic [15:0] wd;
        logic        ww;
        req = r; we = w; lock = l;
        addr0 = a0; wdata0 = d0; addr1 = a1; wdata1 = d1;
        if (eg != 2'b00) begin
            p  = eg[1];
            wa = p ? a1[7:1] : a0[7:1];
            wd = p ? d1 : d0;
            ww = w[p];
            gq.push_back('{32'(cyc), eg, ww, wa, wd});
            if (ww) shadow[wa] = wd;
            else rq.push_back('{32'(cyc + 1), eg, shadow[wa]});
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        step(2'b00, 2'b00, 2'b00, 8'h00, 16'h0, 8'h00, 16'h0, 2'b00);
    endtask

    logic [1:0] seq3 [6];
    logic [1:0] seq4 [8];

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem[i]    = 16'h0;
            shadow[i] = 16'h0;
        end
        seq3 = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        seq4 = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10};

        // Reset with random inputs: all outputs zero
        rst_n = 1'b1;
        req = 2'b00; we = 2'b00; lock = 2'b00;
        addr0 = 8'h0; addr1 = 8'h0; wdata0 = 16'h0; wdata1 = 16'h0;
        #1 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req    = 2'($urandom);
            we     = 2'($urandom);
            lock   = 2'($urandom);
            addr0  = 8'($urandom);
            addr1  = 8'($urandom);
            wdata0 = 16'($urandom);
            wdata1 = 16'($urandom);
            #3;
            check("reset_outputs", 64'({gnt, rvalid, rdata, mem_we, mem_addr, mem_wdata}), 64'(0));
        end
        req = 2'b00; we = 2'b00; lock = 2'b00;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #2;
        check("idle_after_reset", 64'({gnt, mem_we}), 64'(0));
        @(posedge clk); #1;

        // Single write then read on port 0
        step(2'b01, 2'b01, 2'b00, 8'h04, 16'h000A, 8'h00, 16'h0, 2'b01);
        step(2'b01, 2'b00, 2'b00, 8'h04, 16'h0000, 8'h00, 16'h0, 2'b01);
        idle();

        // Contention without lock: strict alternation starting at port 0
        step(2'b10, 2'b00, 2'b00, 8'h04, 16'h0, 8'h10, 16'h0, 2'b10);
        for (int i = 0; i < 6; i++)
            step(2'b11, 2'b00, 2'b00, 8'h04, 16'h1111, 8'h10, 16'h2222, seq3[i]);

        // Port 1 lock: initial grant plus four held grants, then port 0
        step(2'b01, 2'b00, 2'b00, 8'h04, 16'h0, 8'h00, 16'h0, 2'b01);
        for (int i = 0; i < 8; i++)
            step(2'b11, 2'b00, 2'b10, 8'h06, 16'h3333, 8'h12, 16'h4444, seq4[i]);

        // Lock without request grants nothing
        step(2'b00, 2'b00, 2'b11, 8'h04, 16'h0, 8'h10, 16'h0, 2'b00);

        // Write then read of the same word on consecutive cycles; odd byte address
        step(2'b10, 2'b10, 2'b00, 8'h00, 16'h0, 8'h10, 16'hBEEF, 2'b10);
        step(2'b01, 2'b00, 2'b00, 8'h10, 16'h0, 8'h00, 16'h0, 2'b01);
        step(2'b01, 2'b00, 2'b00, 8'h11, 16'h0, 8'h00, 16'h0, 2'b01);
        idle();
        idle();

        // Reset during a read-grant cycle, then a write attempted while in reset
        req = 2'b01; we = 2'b00; lock = 2'b00; addr0 = 8'h04;
        #2 rst_n = 1'b0;
        #1;
        check("rst_gnt", 64'({gnt, mem_we}), 64'(0));
        @(posedge clk); #1;
        req = 2'b10; we = 2'b10; addr1 = 8'h04; wdata1 = 16'hDEAD;
        #1;
        check("rst_mem_we", 64'({gnt, mem_we}), 64'(0));
        @(posedge clk); #1;
        req = 2'b00; we = 2'b00;
        rst_n = 1'b1;
        #1;
        check("rst_rvalid", 64'(rvalid), 64'(0));
        @(posedge clk); #1;
        idle();

        // Memory word survived the reset; address/data hold when idle
        step(2'b01, 2'b00, 2'b00, 8'h04, 16'h5A5A, 8'h00, 16'h0, 2'b01);
        req = 2'b00;
        #2;
        check("hold_mem", 64'({mem_we, mem_addr, mem_wdata}), 64'({1'b0, 7'h02, 16'h5A5A}));
        @(posedge clk); #1;
        idle();
        idle();

        check("gnt_queue_drained", 64'(gq.size()), 64'(0));
        check("rvalid_queue_drained", 64'(rq.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
